mips_muldiv_unit: RTL and testbench
===================================

# mips_muldiv_unit

Parametrised multi-cycle multiply/divide unit owning the HI/LO pair for the MIPS harvard CPU. It executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and handles MTHI/MTLO writes. It sits beside the ALU. The CPU stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO. It generalises the current fixed 32-bit combinational HI/LO path in three ways: parametric width, a selectable fast-multiply mode, and a start/busy/done handshake.

## Interface
- `WIDTH`, 32: operand width; `hi`/`lo` are each WIDTH bits; legal values 8–64.
- `FAST_MUL`, 0: 1 = multiply completes in a single-cycle product; 0 = iterative multiply.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`, with `reset==0` resetting.
- `clk_enable` in 1: 0 holds every register, including `done`.
- `start` in 1: accepts `op`/`a`/`b` when high in IDLE.
- `op` in 3: operation code, from the package enum: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `a` in WIDTH: rs operand, or the dividend.
- `b` in WIDTH: rt operand, or the divisor.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse when `hi`/`lo` take a mul/div result.
- `div_by_zero` out 1: pulses together with `done` when the divisor is 0.
- `hi` out WIDTH: the HI register.
- `lo` out WIDTH: the LO register.

## Operation
- Reset values: `busy` 0, `done` 0, `div_by_zero` 0, `hi` 0, `lo` 0, state IDLE.
- States: IDLE, MUL, DIV, FIXUP.
- IDLE with `start` high:
  - MTHI: `hi`←`a`. Stay in IDLE; no `busy`, no `done`.
  - MTLO: `lo`←`a`. Stay in IDLE; no `busy`, no `done`.
  - MULT/MULTU: go to MUL and load the iteration counter with WIDTH.
  - With `FAST_MUL`=1: the full 2·WIDTH product is written directly and `done` pulses. No MUL state.
  - DIV/DIVU with `b`≠0: go to DIV and load the counter with WIDTH.
  - DIV/DIVU with `b`==0: go straight to completion, with `hi`←`a`, `lo`←all-ones, `div_by_zero` pulse.
- Signed ops: the operand magnitudes are latched at accept, plus the result-sign flags.
  - The product is negated if the operand signs differ.
  - The quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- MUL: shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- DIV: restoring divide, one quotient bit per cycle; the remainder is held in WIDTH+1 bits.
- When the counter reaches 0:
  - Unsigned op: write `hi`/`lo` and go to IDLE.
  - Signed op: go to FIXUP, which applies the negation (two's complement, mod 2^WIDTH or 2^(2·WIDTH)), writes `hi`/`lo`, then returns to IDLE.
- Signed overflow: −2^(WIDTH−1) ÷ −1 gives `lo`=−2^(WIDTH−1), `hi`=0 (natural wrap, no flag).
- `start` while `busy` is ignored; `op`/`a`/`b` do not need to be held after accept.
- `hi`/`lo` are never partially updated. Both change on the same edge, only at completion or on MTHI/MTLO.

## Timing
- Accept edge E (IDLE, `start`=1, `clk_enable`=1): `busy` is 1 from E.
- Completion edges, counted in enabled cycles:
  - MULTU/DIVU: edge E+WIDTH.
  - MULT/DIV: edge E+WIDTH+1.
  - `FAST_MUL` multiply: edge E, with `busy` never high.
  - Divide by zero: edge E, with `busy` never high.
- At the completion edge: `hi`/`lo` updated, `done`=1, `busy`=0.
- On the next enabled edge `done` returns to 0, and a new `start` may be accepted on that same edge.
- `clk_enable`=0 freezes the state, counter, accumulators and all outputs; latency counts only enabled edges.
- Reset mid-operation aborts. The next edge with `reset`==0 forces the reset values regardless of `clk_enable`.

## Structure
- Package `mips_muldiv_pkg` holds:
  - the `muldiv_op_t` enum (3 bits);
  - the `muldiv_state_t` enum;
  - a localparam for the all-ones divide-by-zero quotient pattern.
- Sub-module `mips_muldiv_step` is the combinational single-iteration datapath.
  - Inputs: accumulator, operand, mode (mul/div).
  - Outputs: next accumulator, quotient bit.
- The top level holds the FSM, counter, sign flags, HI/LO registers and the handshake.

## Test plan
- MULTU `a`=0xFFFF_FFFF, `b`=0xFFFF_FFFF (WIDTH=32) -> `done` at E+32, `hi`=0xFFFF_FFFE, `lo`=0x0000_0001.
- MULT `a`=−3, `b`=7 -> `done` at E+33, `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFEB.
  - Repeat with `FAST_MUL`=1: same result, `done` at E, `busy` never high.
- DIV `a`=−7, `b`=2 -> `lo`=0xFFFF_FFFD (−3), `hi`=0xFFFF_FFFF (−1).
  - DIVU `a`=100, `b`=7 -> `lo`=14, `hi`=2, `done` at E+32.
- DIVU `b`=0, `a`=0x1234 -> `done` and `div_by_zero` at E, `hi`=0x1234, `lo`=0xFFFF_FFFF, `busy` never high.
- Handshake/stall cases:
  - MTHI 0xAAAA then MTLO 0x5555 -> `hi`/`lo` updated, no `done`.
  - `start` during `busy` -> ignored, and the result of the first op is intact.
  - `clk_enable` low for 5 cycles mid-MULTU -> `done` delayed exactly 5 cycles, same result.
- Reset mid-DIV at counter 10 -> after that edge, `busy`=0, `hi`=`lo`=0, no `done`.
  - A following DIVU 9/3 completes normally with `lo`=3, `hi`=0.
  - WIDTH=8 regression: MULTU 255×255 -> `hi`=0xFE, `lo`=0x01 at E+8.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the MIPS multiply/divide unit.
package mips_muldiv_pkg;

    // Operation codes presented on op when start is high.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    // Control states of the iterative engine.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_DIV   = 2'd2,
        ST_FIXUP = 2'd3
    } muldiv_state_t;

    // Largest supported operand width.
    localparam int MAX_WIDTH = 64;

    // Quotient reported on divide by zero; the top slices it to WIDTH bits.
    localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the shared multiply/divide datapath.
// Accumulator layout (2*WIDTH+1 bits): upper WIDTH+1 bits are the partial
// product / partial remainder, lower WIDTH bits the multiplier / dividend
// that is consumed one bit per iteration.
module mips_muldiv_step
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  acc_i,
    input  logic [WIDTH-1:0]  operand_i,
    input  logic              div_mode_i,
    output logic [2*WIDTH:0]  acc_o,
    output logic              q_bit_o
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] div_diff;

    // Shift-add multiply step or restoring divide step, chosen by mode.
    always_comb begin
        // NOTE: every combinational output gets a value before any branch, so no latch is inferred.
        acc_o   = '0;
        q_bit_o = 1'b0;

        // Multiply: add the multiplicand when the current multiplier bit is set,
        // then shift the whole accumulator right by one.
        mul_sum = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, operand_i} : '0);

        // Divide: shift the remainder left, pulling in the next dividend bit,
        // and trial-subtract the divisor; a borrow means restore.
        rem_shift = acc_i[2*WIDTH-1:WIDTH-1];
        div_diff  = {1'b0, rem_shift} - {2'b0, operand_i};

        if (div_mode_i) begin
            q_bit_o = ~div_diff[WIDTH+1];
            // Bit 0 is left clear; the caller inserts the quotient bit there.
            acc_o = {(q_bit_o ? div_diff[WIDTH:0] : rem_shift), acc_i[WIDTH-2:0], 1'b0};
        end else begin
            acc_o = {1'b0, mul_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Signed operations run on magnitudes and are corrected in a FIXUP cycle.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FAST_MUL = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              start,
    input  muldiv_op_t        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int CW = $clog2(WIDTH + 1);

    muldiv_state_t       state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic                signed_q, signed_d;
    logic                is_div_q, is_div_d;
    logic                neg_lo_q, neg_lo_d;   // negate product / quotient
    logic                neg_hi_q, neg_hi_d;   // negate remainder
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;

    logic                is_signed_op;
    logic                a_neg, b_neg;
    logic [WIDTH-1:0]    mag_a, mag_b;
    logic [2*WIDTH-1:0]  ext_a, ext_b, fast_prod;
    logic [2*WIDTH:0]    step_acc;
    logic                step_q;

    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i      (acc_q),
        .operand_i  (opnd_q),
        .div_mode_i (state_q == ST_DIV),
        .acc_o      (step_acc),
        .q_bit_o    (step_q)
    );

    // Operand conditioning at accept: magnitudes and the sign-extended fast product.
    always_comb begin
        is_signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg        = is_signed_op & a[WIDTH-1];
        b_neg        = is_signed_op & b[WIDTH-1];
        mag_a        = a_neg ? -a : a;
        mag_b        = b_neg ? -b : b;
        ext_a        = is_signed_op ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        ext_b        = is_signed_op ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        fast_prod    = ext_a * ext_b;
    end

    // Next-state logic: accept, iterate, sign fixup, HI/LO writes and handshake pulses.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        signed_d = signed_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        OP_MULT, OP_MULTU: begin
                            if (FAST_MUL != 0) begin
                                {hi_d, lo_d} = fast_prod;
                                done_d       = 1'b1;
                            end else begin
                                state_d  = ST_MUL;
                                cnt_d    = CW'(WIDTH);
                                acc_d    = {{(WIDTH+1){1'b0}}, mag_b};
                                opnd_d   = mag_a;
                                signed_d = is_signed_op;
                                is_div_d = 1'b0;
                                neg_lo_d = a_neg ^ b_neg;
                                neg_hi_d = 1'b0;
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b == '0) begin
                                hi_d   = a;
                                lo_d   = DIV0_QUOTIENT[WIDTH-1:0];
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                state_d  = ST_DIV;
                                cnt_d    = CW'(WIDTH);
                                acc_d    = {{(WIDTH+1){1'b0}}, mag_a};
                                opnd_d   = mag_b;
                                signed_d = is_signed_op;
                                is_div_d = 1'b1;
                                neg_lo_d = a_neg ^ b_neg;
                                neg_hi_d = a_neg;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_MUL, ST_DIV: begin
                acc_d = (state_q == ST_DIV) ? {step_acc[2*WIDTH:1], step_q} : step_acc;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (signed_q) begin
                        state_d = ST_FIXUP;
                    end else begin
                        state_d      = ST_IDLE;
                        {hi_d, lo_d} = acc_d[2*WIDTH-1:0];
                        done_d       = 1'b1;
                    end
                end
            end

            ST_FIXUP: begin
                if (is_div_q) begin
                    hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
                end
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers: synchronous reset wins over clk_enable.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            signed_q <= 1'b0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else if (clk_enable) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            signed_q <= signed_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: 32-bit iterative, 32-bit fast-multiply
// and 8-bit iterative instances share clock, reset and operand buses.
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic        s32 = 1'b0, sf = 1'b0, s8 = 1'b0;
    muldiv_op_t  op = OP_MTHI;
    logic [31:0] a = '0, b = '0;

    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;
    logic        busyf, donef, dzf;
    logic [31:0] hif, lof;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(32), .FAST_MUL(0)) u32 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(s32), .op(op),
        .a(a), .b(b), .busy(busy32), .done(done32), .div_by_zero(dz32),
        .hi(hi32), .lo(lo32));

    mips_muldiv_unit #(.WIDTH(32), .FAST_MUL(1)) ufast (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(sf), .op(op),
        .a(a), .b(b), .busy(busyf), .done(donef), .div_by_zero(dzf),
        .hi(hif), .lo(lof));

    mips_muldiv_unit #(.WIDTH(8), .FAST_MUL(0)) u8w (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(s8), .op(op),
        .a(a[7:0]), .b(b[7:0]), .busy(busy8), .done(done8), .div_by_zero(dz8),
        .hi(hi8), .lo(lo8));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic g_busy(input int d);
        return (d == 0) ? busy32 : (d == 1) ? busyf : busy8;
    endfunction
    function automatic logic g_done(input int d);
        return (d == 0) ? done32 : (d == 1) ? donef : done8;
    endfunction
    function automatic logic g_dz(input int d);
        return (d == 0) ? dz32 : (d == 1) ? dzf : dz8;
    endfunction
    function automatic logic [31:0] g_hi(input int d);
        return (d == 0) ? hi32 : (d == 1) ? hif : {24'h0, hi8};
    endfunction
    function automatic logic [31:0] g_lo(input int d);
        return (d == 0) ? lo32 : (d == 1) ? lof : {24'h0, lo8};
    endfunction

    // Issue one op to instance d and wait for done; lat counts clock edges after the accept edge.
    task automatic run_op(input int d, input muldiv_op_t o, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] rh, output logic [31:0] rl, output int lat,
                          output bit dz, output bit bz, output bit ok);
        @(negedge clk);
        op = o; a = av; b = bv;
        case (d)
            0: s32 = 1'b1;
            1: sf  = 1'b1;
            default: s8 = 1'b1;
        endcase
        @(posedge clk);
        @(negedge clk);
        s32 = 1'b0; sf = 1'b0; s8 = 1'b0;
        lat = 0; bz = 1'b0; dz = 1'b0; ok = 1'b0; rh = '0; rl = '0;
        while (!g_done(d) && lat < 200) begin
            bz |= g_busy(d);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (g_done(d)) begin
            ok = 1'b1;
            dz = g_dz(d);
            rh = g_hi(d);
            rl = g_lo(d);
        end
    endtask

    typedef struct {
        int          d;
        muldiv_op_t  op;
        logic [31:0] a, b, hi, lo;
        int          lat;
        bit          dz;
    } vec_t;

    vec_t        vecs [15];
    logic [31:0] rh, rl;
    int          lat;
    bit          dz, bz, ok;

    initial begin
        vecs[0]  = '{0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32, 1'b0};
        vecs[1]  = '{0, OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0};
        vecs[2]  = '{1, OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0,  1'b0};
        vecs[3]  = '{0, OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0};
        vecs[4]  = '{0, OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        32, 1'b0};
        vecs[5]  = '{0, OP_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 0,  1'b1};
        vecs[6]  = '{2, OP_MULTU, 32'hFF,        32'hFF,        32'hFE,        32'h01,        8,  1'b0};
        vecs[7]  = '{0, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33, 1'b0};
        vecs[8]  = '{0, OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         33, 1'b0};
        vecs[9]  = '{0, OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33, 1'b0};
        vecs[10] = '{0, OP_DIV,   32'd0,         32'd5,         32'd0,         32'd0,         33, 1'b0};
        vecs[11] = '{1, OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE, 0,  1'b0};
        vecs[12] = '{2, OP_DIV,   32'hF9,        32'd2,         32'hFF,        32'hFD,        9,  1'b0};
        vecs[13] = '{2, OP_DIVU,  32'hFF,        32'd0,         32'hFF,        32'hFF,        0,  1'b1};
        vecs[14] = '{1, OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", busy32, 0);
        check("rst_done", done32, 0);
        check("rst_dbz", dz32, 0);
        check("rst_hi", hi32, 0);
        check("rst_lo", lo32, 0);
        reset = 1'b1;

        // Table-driven arithmetic vectors.
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].d, vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, lat, dz, bz, ok);
            check($sformatf("v%0d_done", i), ok, 1);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_hi", i), rh, vecs[i].hi);
            check($sformatf("v%0d_lo", i), rl, vecs[i].lo);
            check($sformatf("v%0d_dbz", i), dz, vecs[i].dz);
            check($sformatf("v%0d_busy", i), bz, (vecs[i].lat != 0));
            @(negedge clk);
            check($sformatf("v%0d_done_clr", i), g_done(vecs[i].d), 0);
        end

        // MTHI then MTLO: registers written, no done, no busy.
        @(negedge clk);
        op = OP_MTHI; a = 32'hAAAA; s32 = 1'b1;
        @(negedge clk);
        check("mthi_busy", busy32, 0);
        check("mthi_done", done32, 0);
        op = OP_MTLO; a = 32'h5555;
        @(negedge clk);
        s32 = 1'b0;
        check("mtlo_done", done32, 0);
        check("mt_hi", hi32, 32'hAAAA);
        check("mt_lo", lo32, 32'h5555);

        // start while busy is ignored.
        fork
            run_op(0, OP_DIVU, 32'd100, 32'd7, rh, rl, lat, dz, bz, ok);
            begin
                repeat (5) @(negedge clk);
                op = OP_MTHI; a = 32'hDEAD; s32 = 1'b1;
                @(negedge clk);
                s32 = 1'b0;
            end
        join
        check("busy_start_lat", lat, 32);
        check("busy_start_hi", rh, 32'd2);
        check("busy_start_lo", rl, 32'd14);
        repeat (2) @(negedge clk);
        check("busy_start_hi_kept", hi32, 32'd2);

        // clk_enable low for 5 cycles mid-MULTU delays done by exactly 5.
        fork
            run_op(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, lat, dz, bz, ok);
            begin
                repeat (10) @(negedge clk);
                clk_enable = 1'b0;
                repeat (5) @(negedge clk);
                clk_enable = 1'b1;
            end
        join
        check("stall_done", ok, 1);
        check("stall_lat", lat, 37);
        check("stall_hi", rh, 32'hFFFF_FFFE);
        check("stall_lo", rl, 32'h0000_0001);

        // Reset mid-DIV with the counter at 10 (22 steps after accept).
        @(negedge clk);
        op = OP_DIVU; a = 32'hFFFF_FFFF; b = 32'd3; s32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s32 = 1'b0;
        repeat (22) @(negedge clk);
        check("pre_rst_busy", busy32, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_rst_busy", busy32, 0);
        check("mid_rst_hi", hi32, 0);
        check("mid_rst_lo", lo32, 0);
        check("mid_rst_done", done32, 0);
        repeat (3) @(negedge clk);
        check("mid_rst_done_later", done32, 0);

        run_op(0, OP_DIVU, 32'd9, 32'd3, rh, rl, lat, dz, bz, ok);
        check("post_rst_done", ok, 1);
        check("post_rst_lat", lat, 32);
        check("post_rst_hi", rh, 32'd0);
        check("post_rst_lo", rl, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
